// File: rtl/timer_pkg.sv
// Shared types and default sizing for the pulse timer bank.
// Channel state encoding plus the default width and channel count.
package timer_pkg;

  localparam int TIMER_BITWIDTH_DEFAULT = 32;
  localparam int NB_INTERFACES_DEFAULT  = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    CAPTURED = 2'b10
  } ch_state_e;

endpackage

// File: rtl/pulse_timer_ch.sv
// One timer channel: edge-triggered start/capture, saturating counter,
// sticky overflow flag and a single-cycle alarm pulse.
module pulse_timer_ch
  import timer_pkg::*;
#(
  parameter int TIMER_BITWIDTH = TIMER_BITWIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rst_capture,
  input  logic                      start,
  input  logic                      capture,
  input  logic                      alarm_en,
  input  logic [TIMER_BITWIDTH-1:0] alarm,
  output logic [TIMER_BITWIDTH-1:0] counter,
  output logic [TIMER_BITWIDTH-1:0] captured,
  output logic                      alarm_out,
  output logic                      overflow
);

  localparam logic [TIMER_BITWIDTH-1:0] CNT_ZERO = {TIMER_BITWIDTH{1'b0}};
  localparam logic [TIMER_BITWIDTH-1:0] CNT_ONE  = {{(TIMER_BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMER_BITWIDTH-1:0] CNT_MAX  = {TIMER_BITWIDTH{1'b1}};

  ch_state_e                 state_r;
  ch_state_e                 state_s;
  logic [TIMER_BITWIDTH-1:0] counter_r;
  logic [TIMER_BITWIDTH-1:0] counter_s;
  logic [TIMER_BITWIDTH-1:0] captured_r;
  logic [TIMER_BITWIDTH-1:0] captured_s;
  logic                      overflow_r;
  logic                      overflow_s;
  logic                      alarm_out_r;
  logic                      alarm_hit_s;
  logic                      start_q_r;
  logic                      capture_q_r;
  logic                      start_edge_s;
  logic                      capture_edge_s;
  logic                      sat_q_r;
  logic                      sat_s;

  // Rising-edge detection against the previous-cycle copies.
  always_comb begin
    start_edge_s   = start & ~start_q_r;
    capture_edge_s = capture & ~capture_q_r;
  end

  // A saturated counter keeps matching a max-valued threshold, so only the
  // first cycle at saturation is allowed to raise the alarm.
  always_comb begin
    sat_s       = (state_r == COUNTING) && (counter_r == CNT_MAX);
    alarm_hit_s = (state_r == COUNTING) && alarm_en
                  && (counter_r == alarm) && (alarm != CNT_ZERO)
                  && !(sat_q_r && (counter_r == CNT_MAX));
  end

  // Next-state and datapath update; rst_capture outranks start, start outranks capture.
  always_comb begin
    state_s    = state_r;
    counter_s  = counter_r;
    captured_s = captured_r;
    overflow_s = overflow_r;
    if (rst_capture) begin
      state_s    = IDLE;
      counter_s  = CNT_ZERO;
      captured_s = CNT_ZERO;
      overflow_s = 1'b0;
    end else if (start_edge_s) begin
      state_s    = COUNTING;
      counter_s  = CNT_ONE;
      overflow_s = 1'b0;
    end else begin
      case (state_r)
        COUNTING: begin
          if (capture_edge_s) begin
            captured_s = counter_r;
            state_s    = CAPTURED;
          end else if (counter_r != CNT_MAX) begin
            counter_s = counter_r + CNT_ONE;
            if (counter_r == (CNT_MAX - CNT_ONE)) begin
              overflow_s = 1'b1;
            end else begin
              overflow_s = overflow_r;
            end
          end else begin
            counter_s = counter_r;
          end
        end
        IDLE: begin
          state_s = IDLE;
        end
        CAPTURED: begin
          state_s = CAPTURED;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State register, edge registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      counter_r   <= CNT_ZERO;
      captured_r  <= CNT_ZERO;
      overflow_r  <= 1'b0;
      alarm_out_r <= 1'b0;
      start_q_r   <= 1'b0;
      capture_q_r <= 1'b0;
      sat_q_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      counter_r   <= counter_s;
      captured_r  <= captured_s;
      overflow_r  <= overflow_s;
      alarm_out_r <= alarm_hit_s;
      start_q_r   <= start;
      capture_q_r <= capture;
      sat_q_r     <= sat_s;
    end
  end

  assign counter   = counter_r;
  assign captured  = captured_r;
  assign alarm_out = alarm_out_r;
  assign overflow  = overflow_r;

endmodule

// File: rtl/pulse_timer_bank.sv
// Bank of independent pulse timer channels sharing one clock and reset;
// per-channel buses are packed with channel i at [i*TIMER_BITWIDTH +: TIMER_BITWIDTH].
module pulse_timer_bank
  import timer_pkg::*;
#(
  parameter int TIMER_BITWIDTH = TIMER_BITWIDTH_DEFAULT,
  parameter int NB_INTERFACES  = NB_INTERFACES_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NB_INTERFACES-1:0]                rst_capture,
  input  logic [NB_INTERFACES-1:0]                start,
  input  logic [NB_INTERFACES-1:0]                capture,
  input  logic [NB_INTERFACES-1:0]                alarm_en,
  input  logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] alarm,
  output logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] counter,
  output logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] captured,
  output logic [NB_INTERFACES-1:0]                alarm_out,
  output logic [NB_INTERFACES-1:0]                overflow
);

  for (genvar g = 0; g < NB_INTERFACES; g++) begin : g_ch
    pulse_timer_ch #(
      .TIMER_BITWIDTH(TIMER_BITWIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .rst_capture(rst_capture[g]),
      .start      (start[g]),
      .capture    (capture[g]),
      .alarm_en   (alarm_en[g]),
      .alarm      (alarm[g*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .counter    (counter[g*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .captured   (captured[g*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .alarm_out  (alarm_out[g]),
      .overflow   (overflow[g])
    );
  end

endmodule

// File: tb/tb_pulse_timer_bank.sv
// Directed bench for pulse_timer_bank: a 32-bit/10-channel bank plus a
// 4-bit/2-channel bank for saturation behaviour.
module tb_pulse_timer_bank;

  localparam int W  = 32;
  localparam int N  = 10;
  localparam int SW = 4;
  localparam int SN = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  rst_capture, start, capture, alarm_en, alarm_out, overflow;
  logic [W*N-1:0] alarm, counter, captured;

  logic [SN-1:0]    s_rst_capture, s_start, s_capture, s_alarm_en, s_alarm_out, s_overflow;
  logic [SW*SN-1:0] s_alarm, s_counter, s_captured;

  int n_cmp;
  int n_err;

  pulse_timer_bank #(.TIMER_BITWIDTH(W), .NB_INTERFACES(N)) dut (
    .clk(clk), .rst(rst), .rst_capture(rst_capture), .start(start),
    .capture(capture), .alarm_en(alarm_en), .alarm(alarm),
    .counter(counter), .captured(captured), .alarm_out(alarm_out),
    .overflow(overflow)
  );

  pulse_timer_bank #(.TIMER_BITWIDTH(SW), .NB_INTERFACES(SN)) dut_s (
    .clk(clk), .rst(rst), .rst_capture(s_rst_capture), .start(s_start),
    .capture(s_capture), .alarm_en(s_alarm_en), .alarm(s_alarm),
    .counter(s_counter), .captured(s_captured), .alarm_out(s_alarm_out),
    .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt(input int i);
    return counter[i*W +: W];
  endfunction

  function automatic logic [31:0] cap(input int i);
    return captured[i*W +: W];
  endfunction

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    rst_capture = '0; start = '0; capture = '0; alarm_en = '0; alarm = '0;
    s_rst_capture = '0; s_start = '0; s_capture = '0; s_alarm_en = '0; s_alarm = '0;
    step(2);
    chk("reset_counter",   b2w(counter == '0), 32'd1);
    chk("reset_captured",  b2w(captured == '0), 32'd1);
    chk("reset_alarm_out", b2w(alarm_out == '0), 32'd1);
    chk("reset_overflow",  b2w(overflow == '0), 32'd1);
    rst = 1'b0;

    // channel 0: one-cycle start, capture sampled 100 clks later
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    chk("ch0_first_count", cnt(0), 32'd1);
    step(99);
    chk("ch0_count_100", cnt(0), 32'd100);
    capture[0] = 1'b1; capture[1] = 1'b1;
    step(1);
    capture[0] = 1'b0; capture[1] = 1'b0;
    chk("ch0_captured", cap(0), 32'd100);
    chk("ch0_frozen", cnt(0), 32'd100);
    chk("ch1_idle_capture", cap(1), 32'd0);
    chk("ch1_idle_counter", cnt(1), 32'd0);
    step(3);
    chk("ch0_still_frozen", cnt(0), 32'd100);
    chk("others_counter_zero", b2w(counter[W*N-1:2*W] == '0), 32'd1);
    chk("others_captured_zero", b2w(captured[W*N-1:W] == '0), 32'd1);
    capture[0] = 1'b1; step(1); capture[0] = 1'b0;
    chk("ch0_second_capture", cap(0), 32'd100);
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    chk("ch0_restart_count", cnt(0), 32'd1);
    chk("ch0_start_keeps_captured", cap(0), 32'd100);
    rst_capture[0] = 1'b1; step(1); rst_capture[0] = 1'b0;
    chk("ch0_rstcap_counter", cnt(0), 32'd0);
    chk("ch0_rstcap_captured", cap(0), 32'd0);
    step(1);
    chk("ch0_rstcap_idle", cnt(0), 32'd0);

    // alarms: ch3 enabled at 50, ch4 disabled at 50, ch5 enabled at 0
    alarm[3*W +: W] = 32'd50; alarm_en[3] = 1'b1;
    alarm[4*W +: W] = 32'd50; alarm_en[4] = 1'b0;
    alarm[5*W +: W] = 32'd0;  alarm_en[5] = 1'b1;
    start[5:3] = 3'b111; step(1); start[5:3] = 3'b000;
    step(49);
    chk("ch3_count_50", cnt(3), 32'd50);
    chk("ch3_no_early_alarm", b2w(alarm_out[3]), 32'd0);
    step(1);
    chk("ch3_alarm_pulse", b2w(alarm_out[3]), 32'd1);
    chk("ch4_alarm_disabled", b2w(alarm_out[4]), 32'd0);
    chk("ch3_count_51", cnt(3), 32'd51);
    step(1);
    chk("ch3_alarm_one_clk", b2w(alarm_out[3]), 32'd0);
    chk("ch5_alarm_zero_never", b2w(alarm_out[5]), 32'd0);
    start[3] = 1'b1; step(1); start[3] = 1'b0;
    chk("ch3_restart", cnt(3), 32'd1);
    alarm[3*W +: W] = 32'd4;
    step(3);
    chk("ch3_new_thresh_wait", b2w(alarm_out[3]), 32'd0);
    step(1);
    chk("ch3_new_thresh_pulse", b2w(alarm_out[3]), 32'd1);
    alarm_en = '0;

    // ch6: start+capture same clk in IDLE, then rst_capture beats start
    start[6] = 1'b1; capture[6] = 1'b1; step(1); start[6] = 1'b0; capture[6] = 1'b0;
    chk("ch6_start_wins_count", cnt(6), 32'd1);
    chk("ch6_start_wins_captured", cap(6), 32'd0);
    step(1);
    chk("ch6_counting", cnt(6), 32'd2);
    rst_capture[6] = 1'b1; start[6] = 1'b1; step(1); rst_capture[6] = 1'b0;
    chk("ch6_rstcap_wins", cnt(6), 32'd0);
    step(1); start[6] = 1'b0;
    chk("ch6_held_start_no_edge", cnt(6), 32'd0);

    // ch7: start held 5 clks restarts only once
    start[7] = 1'b1; step(5); start[7] = 1'b0;
    chk("ch7_held_start", cnt(7), 32'd5);

    // pulse-width capture: pw=1 on ch8, pw=7 on ch9
    start[8] = 1'b1; step(1); start[8] = 1'b0;
    capture[8] = 1'b1; step(1); capture[8] = 1'b0;
    chk("ch8_pw1", cap(8), 32'd1);
    start[9] = 1'b1; step(1); start[9] = 1'b0;
    step(6);
    capture[9] = 1'b1; step(1); capture[9] = 1'b0;
    chk("ch9_pw7", cap(9), 32'd7);

    // rst mid-count at 30 with a pending alarm; start held across release
    alarm[1*W +: W] = 32'd30; alarm_en[1] = 1'b1;
    start[1] = 1'b1; step(1); start[1] = 1'b0;
    step(29);
    chk("ch1_count_30", cnt(1), 32'd30);
    rst = 1'b1; start[2] = 1'b1;
    step(1);
    chk("rst_mid_counter", b2w(counter == '0), 32'd1);
    chk("rst_mid_captured", b2w(captured == '0), 32'd1);
    chk("rst_mid_alarm_out", b2w(alarm_out == '0), 32'd1);
    chk("rst_mid_overflow", b2w(overflow == '0), 32'd1);
    rst = 1'b0;
    step(1);
    chk("ch2_start_after_release", cnt(2), 32'd1);
    chk("ch1_no_alarm_after_rst", b2w(alarm_out[1]), 32'd0);
    step(1); start[2] = 1'b0;
    chk("ch2_counting", cnt(2), 32'd2);

    // 4-bit bank: saturation, sticky overflow, single alarm at max
    s_alarm[0 +: SW] = 4'd15; s_alarm_en[0] = 1'b1;
    s_start[0] = 1'b1; step(1); s_start[0] = 1'b0;
    chk("s_first_count", {28'd0, s_counter[0 +: SW]}, 32'd1);
    step(13);
    chk("s_count_14", {28'd0, s_counter[0 +: SW]}, 32'd14);
    chk("s_no_overflow_yet", b2w(s_overflow[0]), 32'd0);
    step(1);
    chk("s_count_15", {28'd0, s_counter[0 +: SW]}, 32'd15);
    chk("s_overflow_set", b2w(s_overflow[0]), 32'd1);
    chk("s_alarm_not_yet", b2w(s_alarm_out[0]), 32'd0);
    step(1);
    chk("s_alarm_pulse", b2w(s_alarm_out[0]), 32'd1);
    step(1);
    chk("s_alarm_single", b2w(s_alarm_out[0]), 32'd0);
    step(3);
    chk("s_held_15", {28'd0, s_counter[0 +: SW]}, 32'd15);
    chk("s_overflow_sticky", b2w(s_overflow[0]), 32'd1);
    chk("s_alarm_stays_low", b2w(s_alarm_out[0]), 32'd0);
    s_start[0] = 1'b1; step(1); s_start[0] = 1'b0;
    chk("s_restart_count", {28'd0, s_counter[0 +: SW]}, 32'd1);
    chk("s_restart_overflow", b2w(s_overflow[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
